// File: rtl/counter_share_arbiter_if.sv
// Handshake bundle between the counter consumers and the shared-counter arbiter.
// COUNTER_PAUSE_EN adds the pause input.
interface counter_share_arbiter_if #(
  parameter int CW = 4
);
  logic [1:0]    req;
`ifdef COUNTER_PAUSE_EN
  logic          pause;
`endif
  logic [1:0]    gnt;
  logic          busy;
  logic [CW-1:0] z;
  logic [1:0]    done;

`ifdef COUNTER_PAUSE_EN
  modport master (output req, output pause, input gnt, input busy, input z, input done);
  modport slave  (input req, input pause, output gnt, output busy, output z, output done);
`else
  modport master (output req, input gnt, input busy, input z, input done);
  modport slave  (input req, output gnt, output busy, output z, output done);
`endif
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter owning one shared up-counter; requester 0 counts to LIMIT0, requester 1 to LIMIT1.
// Optional COUNTER_PAUSE_EN freezes the count while pause is high.
//
// state | meaning
// IDLE  | no grant, z=0, picks next winner
// COUNT | counter granted to cur, counting 0..LIM
module counter_share_arbiter #(
  parameter int CW     = 4,
  parameter int LIMIT0 = 3,
  parameter int LIMIT1 = 15
) (
  input logic                      clk,
  input logic                      reset,
  counter_share_arbiter_if.slave   bus
);
  localparam logic [CW-1:0] LIM0 = CW'(LIMIT0);
  localparam logic [CW-1:0] LIM1 = CW'(LIMIT1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] z_q, z_d;
  logic [1:0]    done_q, done_d;
  logic          last_q, last_d;
  logic          cur_q, cur_d;
  logic          win;
  logic          hold;
  logic [CW-1:0] lim;

`ifdef COUNTER_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  assign lim = cur_q ? LIM1 : LIM0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      z_q     <= '0;
      done_q  <= 2'b00;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      z_q     <= z_d;
      done_q  <= done_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    z_d     = z_q;
    done_d  = 2'b00;
    last_d  = last_q;
    cur_d   = cur_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
        z_d    = '0;
        if (bus.req != 2'b00) begin
          // on a tie the requester that did not go last wins
          win     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          cur_d   = win;
          state_d = COUNT;
          gnt_d   = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
        end
      end
      COUNT: begin
        if (!bus.req[cur_q]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
          z_d     = '0;
          last_d  = cur_q;
        end else if (hold) begin
          z_d = z_q;
        end else if (z_q == lim) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
          z_d     = '0;
          done_d  = cur_q ? 2'b10 : 2'b01;
          last_d  = cur_q;
        end else begin
          z_d = z_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.z    = z_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter; covers the pause path when COUNTER_PAUSE_EN is defined.
module tb_counter_share_arbiter;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  counter_share_arbiter_if #(.CW(4)) bus ();

  counter_share_arbiter #(.CW(4), .LIMIT0(3), .LIMIT1(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] g, input logic b,
                     input logic [3:0] zz, input logic [1:0] d);
    logic [8:0] obs, exp;
    obs = {bus.gnt, bus.busy, bus.z, bus.done};
    exp = {g, b, zz, d};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed gnt=%b busy=%b z=%0d done=%b expected gnt=%b busy=%b z=%0d done=%b",
             tag, bus.gnt, bus.busy, bus.z, bus.done, g, b, zz, d);
    end
  endtask

  initial begin
    logic       r;
    logic [3:0] lim;
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    reset = 1'b1;
    bus.req = 2'b01;
`ifdef COUNTER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    #12;
    chk("reset_state", 2'b00, 1'b0, 4'd0, 2'b00);
    reset = 1'b0;

    // requester 0 alone: 4-cycle run then done
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("r0_z%0d", k), 2'b01, 1'b1, 4'(k), 2'b00);
    end
    tick();
    chk("r0_done", 2'b00, 1'b0, 4'd0, 2'b01);
    bus.req = 2'b00;
    tick();
    chk("idle_no_done", 2'b00, 1'b0, 4'd0, 2'b00);

    // requester 1 alone: 16-cycle run, done, immediate re-grant
    bus.req = 2'b10;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("r1_z%0d", k), 2'b10, 1'b1, 4'(k), 2'b00);
    end
    tick();
    chk("r1_done", 2'b00, 1'b0, 4'd0, 2'b10);
    tick();
    chk("r1_regrant", 2'b10, 1'b1, 4'd0, 2'b00);

    // abort at z=7
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("r1b_z%0d", k), 2'b10, 1'b1, 4'(k), 2'b00);
    end
    bus.req = 2'b00;
    tick();
    chk("abort_idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // both requesting: alternate 01,10,01 with one done cycle between runs
    bus.req = 2'b11;
    for (int run = 0; run < 3; run++) begin
      r   = run[0];
      lim = r ? 4'd15 : 4'd3;
      for (int k = 0; k <= int'(lim); k++) begin
        tick();
        chk($sformatf("rr%0d_z%0d", run, k), r ? 2'b10 : 2'b01, 1'b1, 4'(k), 2'b00);
      end
      tick();
      chk($sformatf("rr%0d_done", run), 2'b00, 1'b0, 4'd0, r ? 2'b10 : 2'b01);
    end

    // requester 1 run reset asynchronously at z=9
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("pre_rst_z%0d", k), 2'b10, 1'b1, 4'(k), 2'b00);
    end
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 2'b00, 1'b0, 4'd0, 2'b00);
    #2;
    reset = 1'b0;
    tick();
    chk("post_rst_r0_wins", 2'b01, 1'b1, 4'd0, 2'b00);
    bus.req = 2'b00;
    tick();
    chk("post_rst_abort", 2'b00, 1'b0, 4'd0, 2'b00);

`ifdef COUNTER_PAUSE_EN
    bus.req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("p_z%0d", k), 2'b01, 1'b1, 4'(k), 2'b00);
    end
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("paused_%0d", k), 2'b01, 1'b1, 4'd2, 2'b00);
    end
    bus.pause = 1'b0;
    tick();
    chk("p_z3", 2'b01, 1'b1, 4'd3, 2'b00);
    bus.req = 2'b00;
    tick();
    chk("p_abort_at_lim", 2'b00, 1'b0, 4'd0, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_share_arbiter.md
Name: counter_share_arbiter

Overview:
- Owns one shared CW-bit up-counter and time-shares it between two requesters: requester 0 runs a mod-4 count, requester 1 runs a mod-16 count.
- Round-robin arbiter plus run-control FSM. Grants the counter, sequences one count run from 0 to the requester's limit, pulses done, then releases.
- Sits between the counter-consuming logic and the counter datapath, replacing free-running counters that toggle on their own clock.

Parameters:
- CW, 4: counter width in bits.
- LIMIT0, 3: terminal count for requester 0. Must be < 2^CW.
- LIMIT1, 15: terminal count for requester 1. Must be < 2^CW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  req[i] high = requester i wants a count run; must be held for the whole run.
- gnt  output  2  one-hot grant, registered; 00 when idle.
- busy  output  1  high while any grant is active.
- z  output  CW  current count value, registered.
- done  output  2  one-cycle pulse on done[i] when requester i's run completes normally.

Behaviour:
- Reset (async, any time, including mid-run):
  - gnt=00, busy=0, z=0, done=00, state=IDLE.
  - last=1, so requester 0 wins the first tie.
- State IDLE:
  - gnt=00, busy=0, z=0.
  - If req != 00: pick winner w. A single requester wins. If both request, w = the one that is NOT last.
  - Next cycle: state=COUNT, gnt=onehot(w), busy=1, z=0.
- State COUNT, with LIM = LIMIT0 if w=0, else LIMIT1:
  - req[w]=1 and z<LIM: z<=z+1, gnt held.
  - req[w]=1 and z==LIM: next cycle state=IDLE, gnt=00, busy=0, z=0, done[w]=1, last<=w.
  - req[w]=0 (abort, any z): next cycle state=IDLE, gnt=00, z=0, done=00, last<=w.
  - The other requester's req is ignored during COUNT; no preemption.
- Timing:
  - Run length for requester w = LIM+1 granted cycles, z sequence 0..LIM.
  - At least 1 IDLE cycle between runs; the done pulse coincides with that cycle.
  - Re-grant latency from IDLE = 1 cycle.
- done is high for exactly one cycle, never during COUNT, never on abort.
- Arithmetic:
  - z never exceeds LIM and never wraps through 2^CW.
  - LIMIT=0 gives a 1-cycle run with z=0.
- Simultaneous events:
  - Requester w lowering req on the same cycle that z==LIM counts as an abort: no done.
  - The requester that just finished may re-request immediately. If the other is waiting, the other wins.
- Outputs are driven only from registers; no combinational path from req to gnt/z/done.

Optional Feature:
- Macro: COUNTER_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit) after req.
  - In COUNT with pause=1: z, gnt and state hold.
  - Abort (req[w]=0) still takes priority over pause.
  - pause is ignored in IDLE.
- Undefined: no pause port; the count advances every COUNT cycle.

Test Plan:
- Reset with req=01, then release reset -> gnt=01 one cycle later; z=0,1,2,3 on consecutive cycles; then gnt=00, z=0, done=01 for one cycle.
- req=10 held -> z counts 0..15 over 16 cycles with gnt=10, busy=1 -> done=10 pulse, then re-grant gnt=10 one cycle after the IDLE cycle.
- req=11 held from reset -> grant order 01 (4 cycles), 10 (16 cycles), 01, 10, ...; exactly one idle/done cycle between runs.
- req=10 dropped when z=7 -> next cycle gnt=00, z=0, done=00. Then req=11 -> requester 0 granted first.
- reset asserted asynchronously mid-run at z=9 (between clock edges) -> gnt/z/busy/done go to 0 immediately. After release with req=11 -> requester 0 wins.
- (COUNTER_PAUSE_EN) req=01 with pause=1 at z=2 for 3 cycles -> z stays 2 with gnt=01. Pause released -> z=3, then done=01.
